// File: rtl/mvm_accum_obuf.sv
// MVM lane output stage: framed signed accumulation into a FWFT result FIFO with sticky errors.
// Define MVM_ACCUM_SAT_EN to saturate accumulator adds instead of wrapping.
module mvm_accum_obuf #(
    parameter int IWIDTH     = 24,
    parameter int OWIDTH     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNTW       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ivalid,
    input  logic signed [IWIDTH-1:0] idata,
    input  logic                     accum_first,
    input  logic                     accum_last,
    output logic signed [OWIDTH-1:0] odata,
    output logic                     ovalid,
    input  logic                     oready,
    output logic                     ofull,
    output logic [CNTW-1:0]          count,
    output logic                     ovf_err,
    output logic                     proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                    state, state_nxt;
    logic signed [OWIDTH-1:0]  acc, acc_nxt, din_ext, sum, result, odata_nxt;
    logic signed [OWIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr, rd_nxt;
    logic [CNTW-1:0]           count_nxt;
    logic                      push, push_ok, pop, proto_nxt;

    assign din_ext = OWIDTH'(idata);

`ifdef MVM_ACCUM_SAT_EN
    logic signed [OWIDTH:0] wide;
    always_comb begin
        wide = {acc[OWIDTH-1], acc} + {din_ext[OWIDTH-1], din_ext};
        if (wide[OWIDTH] != wide[OWIDTH-1])
            sum = wide[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
        else
            sum = wide[OWIDTH-1:0];
    end
`else
    assign sum = acc + din_ext;
`endif

    // A word that does not continue an open row always starts a fresh one.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        push      = 1'b0;
        proto_nxt = 1'b0;
        result    = din_ext;
        if (ivalid) begin
            result    = (state == ACCUM && !accum_first) ? sum : din_ext;
            proto_nxt = (state == IDLE) ? !accum_first : accum_first;
            if (accum_last) begin
                push      = 1'b1;
                state_nxt = IDLE;
            end else begin
                acc_nxt   = result;
                state_nxt = ACCUM;
            end
        end
    end

    always_comb begin
        pop     = ovalid && oready;
        push_ok = push && (!ofull || pop);
        rd_nxt  = pop ? rd_ptr + AW'(1) : rd_ptr;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CNTW'(1);
            2'b01:   count_nxt = count - CNTW'(1);
            default: count_nxt = count;
        endcase
        // New head bypasses the array when the pushed word lands in the head slot.
        if (count_nxt == '0)
            odata_nxt = '0;
        else if (push_ok && wr_ptr == rd_nxt)
            odata_nxt = result;
        else
            odata_nxt = mem[rd_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            odata     <= '0;
            ovalid    <= 1'b0;
            ofull     <= 1'b0;
            ovf_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            rd_ptr    <= rd_nxt;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            count     <= count_nxt;
            odata     <= odata_nxt;
            ovalid    <= (count_nxt != '0);
            ofull     <= (count_nxt == CNTW'(FIFO_DEPTH));
            ovf_err   <= ovf_err | (push & !push_ok);
            proto_err <= proto_err | proto_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= result;
    end
endmodule

// File: tb/tb_mvm_accum_obuf.sv
// Self-checking bench for mvm_accum_obuf: directed scenarios plus randomized framing vs a queue model.
module tb_mvm_accum_obuf;
    localparam int DEPTH = 8;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic               ivalid = 0, accum_first = 0, accum_last = 0, oready = 0;
    logic signed [23:0] idata = '0;
    logic signed [31:0] odata;
    logic               ovalid, ofull, ovf_err, proto_err;
    logic [3:0]         count;

    logic              iv8 = 0, f8 = 0, l8 = 0, or8 = 0;
    logic signed [7:0] id8 = '0, od8;
    logic              ov8, of8, ovf8, pe8;
    logic [3:0]        cnt8;

    mvm_accum_obuf dut (
        .clk(clk), .rst(rst), .ivalid(ivalid), .idata(idata),
        .accum_first(accum_first), .accum_last(accum_last),
        .odata(odata), .ovalid(ovalid), .oready(oready), .ofull(ofull),
        .count(count), .ovf_err(ovf_err), .proto_err(proto_err));

    mvm_accum_obuf #(.IWIDTH(8), .OWIDTH(8), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .ivalid(iv8), .idata(id8),
        .accum_first(f8), .accum_last(l8),
        .odata(od8), .ovalid(ov8), .oready(or8), .ofull(of8),
        .count(cnt8), .ovf_err(ovf8), .proto_err(pe8));

    int total = 0, bad = 0;

    // Behavioural model: open-row flag, running sum, queue of results.
    bit      row_open, m_ovf, m_proto;
    longint  m_acc;
    longint  q[$];

    function automatic longint fit32(input longint x);
        logic [31:0] t;
`ifdef MVM_ACCUM_SAT_EN
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
`else
        t = x[31:0];
        return longint'($signed(t));
`endif
    endfunction

    task automatic model_clear();
        row_open = 0; m_ovf = 0; m_proto = 0; m_acc = 0; q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ivalid = 0; accum_first = 0; accum_last = 0; oready = 0; idata = '0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit v, input longint d, input bit f, input bit l, input bit r);
        bit pop, do_push;
        longint val;
        ivalid = v; idata = d[23:0]; accum_first = f; accum_last = l; oready = r;
        @(posedge clk);
        pop = (q.size() > 0) && r;
        do_push = 0;
        val = d;
        if (v) begin
            if (row_open == f) m_proto = 1;
            if (row_open && !f) val = fit32(m_acc + d);
            if (l) begin
                row_open = 0;
                if (q.size() < DEPTH || pop) do_push = 1; else m_ovf = 1;
            end else begin
                m_acc = val;
                row_open = 1;
            end
        end
        if (pop) void'(q.pop_front());
        if (do_push) q.push_back(val);
        @(negedge clk);
        ivalid = 0; accum_first = 0; accum_last = 0; oready = 0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (odata !== 0 || ovalid !== 0 || ofull !== 0 || count !== 0 || ovf_err !== 0 || proto_err !== 0) begin
            bad++;
            $display("FAIL reset: odata=%0d ovalid=%b ofull=%b count=%0d ovf=%b proto=%b, required all 0",
                     odata, ovalid, ofull, count, ovf_err, proto_err);
        end
        do_reset();
    endtask

    task automatic test_row_sum();
        do_reset();
        step(1, 3, 1, 0, 1);
        step(1, -5, 0, 0, 1);
        step(1, 10, 0, 1, 1);
        total++;
        if (ovalid !== 1 || odata !== 8) begin
            bad++; $display("FAIL row_sum: ovalid=%b odata=%0d, required 1 / 8", ovalid, odata);
        end
        step(0, 0, 0, 0, 1);
        total++;
        if (ovalid !== 0 || count !== 0 || proto_err !== 0 || ovf_err !== 0) begin
            bad++; $display("FAIL row_sum_drain: ovalid=%b count=%0d proto=%b ovf=%b, required 0", ovalid, count, proto_err, ovf_err);
        end
    endtask

    task automatic test_single_neg();
        step(1, -7, 1, 1, 0);
        total++;
        if (odata !== -7 || count !== 1) begin
            bad++; $display("FAIL single_neg: odata=%0d count=%0d, required -7 / 1", odata, count);
        end
        step(0, 0, 0, 0, 1);
        total++;
        if (count !== 0 || ovalid !== 0) begin
            bad++; $display("FAIL single_neg_pop: count=%0d ovalid=%b, required 0 / 0", count, ovalid);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 1; i <= 8; i++) step(1, i * 10, 1, 1, 0);
        total++;
        if (count !== 8 || ofull !== 1) begin
            bad++; $display("FAIL fill: count=%0d ofull=%b, required 8 / 1", count, ofull);
        end
        step(1, 99, 1, 1, 1);
        total++;
        if (count !== 8 || ofull !== 1 || ovf_err !== 0 || odata !== 20) begin
            bad++; $display("FAIL full_pushpop: count=%0d ofull=%b ovf=%b odata=%0d, required 8 / 1 / 0 / 20",
                            count, ofull, ovf_err, odata);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) step(1, i, 1, 1, 0);
        total++;
        if (count !== 8 || ofull !== 1 || ovf_err !== 1) begin
            bad++; $display("FAIL overflow: count=%0d ofull=%b ovf=%b, required 8 / 1 / 1", count, ofull, ovf_err);
        end
        step(0, 0, 0, 0, 0);
        total++;
        if (odata !== 1 || ovalid !== 1) begin
            bad++; $display("FAIL hold: odata=%0d ovalid=%b, required 1 / 1", odata, ovalid);
        end
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (odata !== i || ovalid !== 1) begin
                bad++; $display("FAIL drain[%0d]: odata=%0d ovalid=%b, required %0d / 1", i, odata, ovalid, i);
            end
            step(0, 0, 0, 0, 1);
        end
        total++;
        if (count !== 0 || ofull !== 0 || ovalid !== 0 || ovf_err !== 1) begin
            bad++; $display("FAIL drained: count=%0d ofull=%b ovalid=%b ovf=%b, required 0 / 0 / 0 / 1",
                            count, ofull, ovalid, ovf_err);
        end
    endtask

    task automatic test_proto();
        do_reset();
        step(1, 4, 0, 1, 0);
        total++;
        if (proto_err !== 1 || odata !== 4 || ovalid !== 1) begin
            bad++; $display("FAIL proto_idle: proto=%b odata=%0d ovalid=%b, required 1 / 4 / 1", proto_err, odata, ovalid);
        end
        step(0, 0, 0, 0, 1);
        step(1, 5, 1, 0, 0);
        step(1, 6, 1, 1, 0);
        total++;
        if (odata !== 6 || count !== 1 || proto_err !== 1) begin
            bad++; $display("FAIL proto_restart: odata=%0d count=%0d proto=%b, required 6 / 1 / 1", odata, count, proto_err);
        end
    endtask

    task automatic test_sat();
        logic signed [7:0] exp8;
`ifdef MVM_ACCUM_SAT_EN
        exp8 = 8'sd127;
`else
        exp8 = -8'sd56;
`endif
        iv8 = 1; id8 = 8'sd100; f8 = 1; l8 = 0; or8 = 0;
        @(negedge clk);
        f8 = 0; l8 = 1;
        @(negedge clk);
        iv8 = 0; l8 = 0;
        total++;
        if (ov8 !== 1 || od8 !== exp8 || cnt8 !== 1) begin
            bad++; $display("FAIL sat8: ovalid=%b odata=%0d count=%0d, required 1 / %0d / 1", ov8, od8, cnt8, exp8);
        end
    endtask

    task automatic test_random();
        bit v, f, l, r;
        logic [23:0] t;
        logic signed [31:0] e;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 9) < 7);
            f = row_open ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 19) != 0);
            l = ($urandom_range(0, 2) == 0);
            r = ((i % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            t = 24'($urandom);
            step(v, longint'($signed(t)), f, l, r);
            e = (q.size() > 0) ? 32'(q[0]) : 32'sd0;
            total++;
            if (ovalid !== (q.size() > 0) || odata !== e || count !== 4'(q.size()) ||
                ofull !== (q.size() == DEPTH) || ovf_err !== m_ovf || proto_err !== m_proto) begin
                bad++;
                $display("FAIL random[%0d]: ovalid=%b odata=%0d count=%0d ofull=%b ovf=%b proto=%b, required %b/%0d/%0d/%b/%b/%b",
                         i, ovalid, odata, count, ofull, ovf_err, proto_err,
                         q.size() > 0, e, q.size(), q.size() == DEPTH, m_ovf, m_proto);
            end
        end
    endtask

    task automatic test_reset_midrow();
        do_reset();
        step(1, 1, 1, 1, 0);
        step(1, 2, 1, 1, 0);
        step(1, 5, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        total++;
        if (odata !== 0 || ovalid !== 0 || ofull !== 0 || count !== 0 || ovf_err !== 0 || proto_err !== 0) begin
            bad++; $display("FAIL reset_midrow: odata=%0d ovalid=%b count=%0d ovf=%b proto=%b, required all 0",
                            odata, ovalid, count, ovf_err, proto_err);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step(1, 7, 1, 1, 0);
        total++;
        if (odata !== 7 || count !== 1 || proto_err !== 0) begin
            bad++; $display("FAIL after_reset: odata=%0d count=%0d proto=%b, required 7 / 1 / 0", odata, count, proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_row_sum();
        test_single_neg();
        test_full_pushpop();
        test_overflow();
        test_proto();
        do_reset();
        test_sat();
        test_random();
        test_reset_midrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
